// File: rtl/reg_scoreboard.sv
// In-order register-write scoreboard: tracks pending destination writes, stalls decode on RAW or full.
// Optional build macro SCOREBOARD_BYPASS_EN lets a retiring writeback forward to decode in the same cycle.
module reg_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int REG_W    = 4,
  parameter int DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dec_valid,
  input  logic                         dec_writes,
  input  logic [REG_W-1:0]             dec_dst,
  input  logic                         dec_src_a_valid,
  input  logic [REG_W-1:0]             dec_src_a,
  input  logic                         dec_src_b_valid,
  input  logic [REG_W-1:0]             dec_src_b,
  input  logic                         wb_valid,
  input  logic [REG_W-1:0]             wb_dst,
  input  logic                         flush,
  input  logic [$clog2(DEPTH+1)-1:0]   flush_keep,
  output logic                         stall,
  output logic [NUM_REGS-1:0]          busy,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         error
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [REG_W-1:0] ent_q [DEPTH];
  logic [REG_W-1:0] ent_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d, rem;
  logic             error_q, error_d;
  logic             raw_a, raw_b, accept, pop;

  // Only entries inside the head..count window are live; stale slots are ignored.
  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_q)
        busy[ent_q[head_q + PTR_W'(i)]] = 1'b1;
    end
  end

  assign pop = wb_valid & (count_q != '0);

`ifdef SCOREBOARD_BYPASS_EN
  logic [NUM_REGS-1:0] busy_young;
  logic                fwd_a, fwd_b;

  always_comb begin
    busy_young = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_q)
        busy_young[ent_q[head_q + PTR_W'(i)]] = 1'b1;
    end
  end

  assign fwd_a = pop & (ent_q[head_q] == dec_src_a) & ~busy_young[dec_src_a];
  assign fwd_b = pop & (ent_q[head_q] == dec_src_b) & ~busy_young[dec_src_b];
  assign raw_a = dec_src_a_valid & busy[dec_src_a] & ~fwd_a;
  assign raw_b = dec_src_b_valid & busy[dec_src_b] & ~fwd_b;
`else
  assign raw_a = dec_src_a_valid & busy[dec_src_a];
  assign raw_b = dec_src_b_valid & busy[dec_src_b];
`endif

  // full is taken from pre-pop state, so a pop never frees a slot for the same-cycle writer.
  assign full   = (count_q == CNT_W'(DEPTH));
  assign stall  = dec_valid & ~flush & (raw_a | raw_b | (dec_writes & full));
  assign accept = dec_valid & dec_writes & ~stall & ~flush;
  assign rem    = count_q - CNT_W'(pop);

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q;
    count_d = count_q;
    error_d = error_q | (wb_valid & ((count_q == '0) | (ent_q[head_q] != wb_dst)));
    if (flush) begin
      count_d = (flush_keep < rem) ? flush_keep : rem;
      tail_d  = head_d + count_d[PTR_W-1:0];
    end else begin
      if (accept) ent_d[tail_q] = dec_dst;
      tail_d  = tail_q + PTR_W'(accept);
      count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      error_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      error_q <= error_d;
      ent_q   <= ent_d;
    end
  end

  assign count = count_q;
  assign error = error_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard; inputs change and outputs are sampled around the falling edge.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid, dec_writes, dec_src_a_valid, dec_src_b_valid;
  logic [3:0]  dec_dst, dec_src_a, dec_src_b, wb_dst;
  logic        wb_valid, flush;
  logic [2:0]  flush_keep;
  logic        stall, full, error;
  logic [15:0] busy;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  reg_scoreboard #(.NUM_REGS(16), .REG_W(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_writes(dec_writes), .dec_dst(dec_dst),
    .dec_src_a_valid(dec_src_a_valid), .dec_src_a(dec_src_a),
    .dec_src_b_valid(dec_src_b_valid), .dec_src_b(dec_src_b),
    .wb_valid(wb_valid), .wb_dst(wb_dst),
    .flush(flush), .flush_keep(flush_keep),
    .stall(stall), .busy(busy), .count(count), .full(full), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    dec_valid = 0; dec_writes = 0; dec_dst = 0;
    dec_src_a_valid = 0; dec_src_a = 0; dec_src_b_valid = 0; dec_src_b = 0;
    wb_valid = 0; wb_dst = 0; flush = 0; flush_keep = 0;
  endtask

  // advance one clock, return just after the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [3:0] d);
    idle();
    dec_valid = 1; dec_writes = 1; dec_dst = d;
    step();
    idle();
  endtask

  task automatic retire(input logic [3:0] d);
    idle();
    wb_valid = 1; wb_dst = d;
    step();
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    step(); step();
    rst = 0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_stall", stall, 0);
    chk("rst_error", error, 0);

    // single write, RAW stall, retire
    dec_valid = 1; dec_writes = 1; dec_dst = 3;
    #1 chk("t1_accept_stall", stall, 0);
    step(); idle();
    dec_valid = 1; dec_src_a_valid = 1; dec_src_a = 3;
    #1;
    chk("t1_raw_stall", stall, 1);
    chk("t1_busy", busy, 16'h0008);
    chk("t1_count", count, 1);
    retire(3);
    #1;
    chk("t1_busy_clr", busy, 0);
    chk("t1_count_clr", count, 0);
    dec_valid = 1; dec_src_a_valid = 1; dec_src_a = 3;
    #1 chk("t1_stall_clr", stall, 0);
    idle();

    // fill, full stall, stall persists on pop cycle
    push(1); push(2); push(5); push(7);
    #1;
    chk("t2_full", full, 1);
    chk("t2_count", count, 4);
    chk("t2_busy", busy, 16'h00A6);
    dec_valid = 1; dec_writes = 1; dec_dst = 8;
    #1 chk("t2_full_stall", stall, 1);
    wb_valid = 1; wb_dst = 1;
    #1 chk("t2_full_pop_stall", stall, 1);
    step();
    wb_valid = 0;
    #1;
    chk("t2_count_after_pop", count, 3);
    chk("t2_writer_free", stall, 0);
    step(); idle();
    #1;
    chk("t2_count_accept", count, 4);
    chk("t2_busy_accept", busy, 16'h01A4);

    // drain, refill, flush keeping the oldest
    retire(2); retire(5); retire(7); retire(8);
    #1;
    chk("t3_drained", count, 0);
    chk("t3_no_err", error, 0);
    push(1); push(2); push(5); push(7);
    flush = 1; flush_keep = 1;
    dec_valid = 1; dec_src_a_valid = 1; dec_src_a = 2;
    #1 chk("t3_flush_no_stall", stall, 0);
    step(); idle();
    #1;
    chk("t3_flush_count", count, 1);
    chk("t3_flush_busy", busy, 16'h0002);
    push(9);
    #1;
    chk("t3_wrap_count", count, 2);
    chk("t3_wrap_busy", busy, 16'h0202);
    // flush with pop in the same cycle, keep larger than remainder
    wb_valid = 1; wb_dst = 1; flush = 1; flush_keep = 4;
    step(); idle();
    #1;
    chk("t3_flushpop_count", count, 1);
    chk("t3_flushpop_busy", busy, 16'h0200);
    chk("t3_flushpop_err", error, 0);
    retire(9);

    // underflow
    retire(6);
    #1;
    chk("t4_underflow_err", error, 1);
    chk("t4_underflow_count", count, 0);
    rst = 1; step(); rst = 0;
    #1 chk("t4_rst_err", error, 0);
    // mismatch still pops
    push(4);
    retire(6);
    #1;
    chk("t4_mismatch_err", error, 1);
    chk("t4_mismatch_count", count, 0);
    chk("t4_mismatch_busy", busy, 0);
    step(); step();
    #1 chk("t4_err_sticky", error, 1);

    // same-cycle writeback forwarding
    rst = 1; step(); rst = 0;
    push(2);
    dec_valid = 1; dec_src_b_valid = 1; dec_src_b = 2;
    wb_valid = 1; wb_dst = 2;
`ifdef SCOREBOARD_BYPASS_EN
    #1 chk("t5_bypass_stall", stall, 0);
`else
    #1 chk("t5_bypass_stall", stall, 1);
`endif
    step(); idle();
    push(2); push(2);
    dec_valid = 1; dec_src_b_valid = 1; dec_src_b = 2;
    wb_valid = 1; wb_dst = 2;
    #1 chk("t5_dup_stall", stall, 1);
    step(); idle();
    #1 chk("t5_dup_count", count, 1);
    retire(2);

    // reset mid-operation with flush high
    push(1); push(2); push(3); push(4);
    retire(9);
    #1;
    chk("t6_pre_count", count, 3);
    chk("t6_pre_err", error, 1);
    rst = 1; flush = 1; flush_keep = 2;
    dec_valid = 1; dec_writes = 1; dec_dst = 5;
    step();
    rst = 0; idle();
    dec_valid = 1; dec_src_a_valid = 1; dec_src_a = 2;
    #1;
    chk("t6_count", count, 0);
    chk("t6_busy", busy, 0);
    chk("t6_stall", stall, 0);
    chk("t6_error", error, 0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
